// File: rtl/i_cache_burst_if.sv
// Fetch-side and refill-side signals of the burst instruction cache, grouped so
// the environment (master) and the cache (slave) share one bundle.
interface i_cache_burst_if;
  logic [31:0] i_Addr;
  logic        i_Flush;
  logic [31:0] o_Data;
  logic        o_Stall;
  logic        o_MemReq;
  logic [31:0] o_MemAddr;
  logic [31:0] i_MemData;
  logic        i_MemValid;
  logic [31:0] o_HitCnt;
  logic [31:0] o_MissCnt;

  modport master (
    output i_Addr, i_Flush, i_MemData, i_MemValid,
    input  o_Data, o_Stall, o_MemReq, o_MemAddr, o_HitCnt, o_MissCnt
  );

  modport slave (
    input  i_Addr, i_Flush, i_MemData, i_MemValid,
    output o_Data, o_Stall, o_MemReq, o_MemAddr, o_HitCnt, o_MissCnt
  );
endinterface

// File: rtl/i_cache_burst.sv
// Direct-mapped instruction cache with in-order burst refill, fence.i flush
// (deferred until an active refill finishes) and saturating hit/miss counters.
module i_cache_burst #(
  parameter int BLOCK_WORDS = 4,
  parameter int ENTRIES     = 64
) (
  input logic            i_clk,
  input logic            i_rst,
  i_cache_burst_if.slave bus
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int WORDS  = ENTRIES * BLOCK_WORDS;

  typedef enum logic [1:0] {
    COMPARE = 2'd0,
    REFILL  = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ENTRIES-1:0] valid_reg;
  logic [ENTRIES-1:0] valid_next;
  logic [TAG_W-1:0]   miss_tag_reg;
  logic [IDX_W-1:0]   miss_idx_reg;
  logic [OFF_W-1:0]   beat_reg;
  logic               flush_pend_reg;
  logic               mem_req_reg;
  logic [31:0]        hit_cnt_reg;
  logic [31:0]        miss_cnt_reg;

  // Tag and data storage carry no reset; the valid bits guard them.
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [31:0]        data_mem [WORDS];

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               in_compare;
  logic               hit;
  logic               start_refill;
  logic               beat_accept;
  logic               last_beat;
  logic               refill_done;
  logic               flush_after;
  logic               unused_addr_bits;

  assign cpu_off = bus.i_Addr[2 +: OFF_W];
  assign cpu_idx = bus.i_Addr[2 + OFF_W +: IDX_W];
  assign cpu_tag = bus.i_Addr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.i_Addr[1:0];

  assign in_compare   = (state_reg == COMPARE);
  assign hit          = in_compare && valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign start_refill = in_compare && !bus.i_Flush && !hit;
  assign beat_accept  = (state_reg == REFILL) && bus.i_MemValid;
  assign last_beat    = (beat_reg == OFF_W'(BLOCK_WORDS - 1));
  assign refill_done  = beat_accept && last_beat;
  // A flush arriving with the final beat is treated the same as one already pending.
  assign flush_after  = flush_pend_reg || bus.i_Flush;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
      assign valid_next[gi] =
          (state_reg == FLUSH)                                         ? 1'b0 :
          (start_refill && (cpu_idx == IDX_W'(gi)))                    ? 1'b0 :
          (refill_done && !flush_after && (miss_idx_reg == IDX_W'(gi))) ? 1'b1 :
                                                                         valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (beat_accept) begin
      data_mem[{miss_idx_reg, beat_reg}] <= bus.i_MemData;
    end
    if (refill_done) begin
      tag_mem[miss_idx_reg] <= miss_tag_reg;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= COMPARE;
      beat_reg       <= '0;
      flush_pend_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      miss_tag_reg   <= '0;
      miss_idx_reg   <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        COMPARE: begin
          if (bus.i_Flush) begin
            state_reg <= FLUSH;
          end else if (!hit) begin
            state_reg    <= REFILL;
            mem_req_reg  <= 1'b1;
            miss_tag_reg <= cpu_tag;
            miss_idx_reg <= cpu_idx;
            beat_reg     <= '0;
            if (miss_cnt_reg != 32'hFFFF_FFFF) begin
              miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
          end
        end
        REFILL: begin
          if (bus.i_Flush) begin
            flush_pend_reg <= 1'b1;
          end
          if (bus.i_MemValid) begin
            beat_reg <= beat_reg + OFF_W'(1);
            if (last_beat) begin
              mem_req_reg <= 1'b0;
              state_reg   <= flush_after ? FLUSH : COMPARE;
            end
          end
        end
        FLUSH: begin
          flush_pend_reg <= 1'b0;
          state_reg      <= COMPARE;
        end
        default: begin
          state_reg <= COMPARE;
        end
      endcase

      if (hit && !bus.i_Flush && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.o_Data    = hit ? data_mem[{cpu_idx, cpu_off}] : 32'd0;
  assign bus.o_Stall   = !hit;
  assign bus.o_MemReq  = mem_req_reg;
  assign bus.o_MemAddr = mem_req_reg ? {miss_tag_reg, miss_idx_reg, beat_reg, 2'b00}
                                     : {bus.i_Addr[31:2], 2'b00};
  assign bus.o_HitCnt  = hit_cnt_reg;
  assign bus.o_MissCnt = miss_cnt_reg;

endmodule

// File: tb/tb_i_cache_burst.sv
// Scoreboard bench for i_cache_burst: stimulus queues expected fetch words and
// refill beat addresses, a monitor pops them as the cache presents them.
module tb_i_cache_burst;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i_cache_burst_if bus ();

  i_cache_burst #(
    .BLOCK_WORDS(4),
    .ENTRIES    (64)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  bit          mon_en    = 1'b0;
  bit          wait_mode = 1'b0;
  bit          phase     = 1'b1;
  logic [31:0] exp_hits   = 32'd0;
  logic [31:0] exp_misses = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'h0000_00A0 | {28'h0, 2'b00, a[3:2]};
    if (a[31:4] == 28'h0000163) return 32'h0000_00B0 | {28'h0, 2'b00, a[3:2]};
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hit_cnt"},  bus.o_HitCnt,  exp_hits);
    check({tag, "_miss_cnt"}, bus.o_MissCnt, exp_misses);
  endtask

  // Memory: answers every refill cycle, optionally with a 1,0,1,0 valid pattern.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.o_MemReq === 1'b1) begin
        bus.i_MemValid = wait_mode ? phase : 1'b1;
        bus.i_MemData  = mem_word(bus.o_MemAddr);
        phase          = ~phase;
      end else begin
        bus.i_MemValid = 1'b0;
        bus.i_MemData  = 32'd0;
        phase          = 1'b1;
      end
    end
  end

  // Monitor: every satisfied fetch and every refill cycle is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b0) begin
        if (bus.o_Stall === 1'b0) begin
          if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_data: unexpected hit addr 0x%08h data 0x%08h, required stall",
                     bus.i_Addr, bus.o_Data);
          end else begin
            check("fetch_data", bus.o_Data, exp_data_q.pop_front());
          end
        end
        if (bus.o_MemReq === 1'b1) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_addr: unexpected request 0x%08h, required none", bus.o_MemAddr);
          end else if (bus.i_MemValid === 1'b1) begin
            check("beat_addr", bus.o_MemAddr, exp_addr_q.pop_front());
          end else begin
            check("hold_addr", bus.o_MemAddr, exp_addr_q[0]);
          end
        end
      end
    end
  end

  // Miss on addr, expect `refills` complete bursts, then a hit returning data
  // after exactly `lat` stalled cycles; optional one-cycle flush at cycle flush_cyc.
  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data,
                            input int lat, input int refills, input int flush_cyc);
    int          stalls;
    bit          done;
    logic [31:0] base;
    stalls = 0;
    done   = 1'b0;
    base   = {addr[31:4], 4'h0};
    for (int r = 0; r < refills; r++) begin
      for (int b = 0; b < 4; b++) exp_addr_q.push_back(base + 32'(4 * b));
    end
    exp_data_q.push_back(data);
    bus.i_Addr = addr;
    for (int c = 0; c < 60 && !done; c++) begin
      bus.i_Flush = (c == flush_cyc);
      @(negedge clk);
      if (bus.o_Stall === 1'b0) begin
        done = 1'b1;
      end else begin
        stalls++;
        step();
      end
    end
    bus.i_Flush = 1'b0;
    exp_misses  = exp_misses + 32'(refills);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL refill_timeout: addr 0x%08h still stalled after %0d cycles, required %0d",
               addr, stalls, lat);
    end else begin
      check($sformatf("miss_latency_%08h", addr), 32'(stalls), 32'(lat));
      check("miss_cnt_at_hit", bus.o_MissCnt, exp_misses);
      step();
      exp_hits = exp_hits + 32'd1;
    end
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
    exp_data_q.push_back(data);
    bus.i_Addr = addr;
    @(negedge clk);
    check($sformatf("hit_stall_%08h", addr), 32'(bus.o_Stall), 32'd0);
    step();
    exp_hits = exp_hits + 32'd1;
  endtask

  // Flush held for n cycles on a hitting address: first cycle still shows the
  // word but is not counted, then FLUSH/COMPARE alternate with stall.
  task automatic flush_hold(input logic [31:0] addr, input logic [31:0] data, input int n);
    exp_data_q.push_back(data);
    bus.i_Addr  = addr;
    bus.i_Flush = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c > 0) check("flush_stall", 32'(bus.o_Stall), 32'd1);
      step();
    end
    bus.i_Flush = 1'b0;
    check_counts("after_flush");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.i_Addr     = 32'h0000_1238;
    bus.i_Flush    = 1'b0;
    bus.i_MemValid = 1'b0;
    bus.i_MemData  = 32'd0;
    mon_en         = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("reset_stall",  32'(bus.o_Stall),  32'd1);
    check("reset_data",   bus.o_Data,        32'd0);
    check("reset_memreq", 32'(bus.o_MemReq), 32'd0);
    check_counts("reset");
    step();
    rst = 1'b0;

    // Cold miss, then same-line hits.
    fetch_miss(32'h0000_1238, 32'h0000_00A2, 5, 1, -1);
    fetch_hit(32'h0000_1230, 32'h0000_00A0);
    fetch_hit(32'h0000_1234, 32'h0000_00A1);
    fetch_hit(32'h0000_123C, 32'h0000_00A3);
    check_counts("same_line");

    // Conflict on index 0x23.
    fetch_miss(32'h0000_1630, 32'h0000_00B0, 5, 1, -1);
    fetch_miss(32'h0000_1230, 32'h0000_00A0, 5, 1, -1);
    check_counts("conflict");

    // Flush during beat 1: burst completes, FLUSH, then a second full refill.
    fetch_miss(32'h0000_2008, 32'hC0DE_2008, 11, 2, 2);
    check_counts("flush_refill");

    flush_hold(32'h0000_2008, 32'hC0DE_2008, 4);
    fetch_miss(32'h0000_2008, 32'hC0DE_2008, 5, 1, -1);

    // Wait states: three idle cycles inside the burst.
    wait_mode = 1'b1;
    fetch_miss(32'h0000_3004, 32'hC0DE_3004, 8, 1, -1);
    check_counts("wait_states");

    // Reset between beats 2 and 3 of a refill.
    exp_addr_q.push_back(32'h0000_4010);
    exp_addr_q.push_back(32'h0000_4014);
    exp_addr_q.push_back(32'h0000_4018);
    bus.i_Addr = 32'h0000_4010;
    repeat (6) step();
    rst        = 1'b1;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    #1;
    check("memreq_on_reset", 32'(bus.o_MemReq), 32'd0);
    @(negedge clk);
    check("reset_mid_stall", 32'(bus.o_Stall), 32'd1);
    check("reset_mid_data",  bus.o_Data,       32'd0);
    check_counts("reset_mid");
    step();
    rst       = 1'b0;
    wait_mode = 1'b0;
    fetch_miss(32'h0000_4010, 32'hC0DE_4010, 5, 1, -1);
    check_counts("after_reset");

    mon_en = 1'b0;
    check("data_queue_left", 32'(exp_data_q.size()), 32'd0);
    check("addr_queue_left", 32'(exp_addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
